// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding, byte width and timeout helper.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_e;

  localparam int UART_BYTE_W      = 8;
  localparam int DEF_CLK_PER_BITS = 1086;

  // One UART frame is 10 bit times; a watchdog shorter than that would abort healthy transfers.
  function automatic int min_timeout(input int clk_per_bits);
    return 10 * clk_per_bits;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle of the UART TX arbiter; slave = arbiter, master = requesters + serializer.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
);

  // Handshake: a requester holds req[i] with stable req_data/req_last until the one-cycle ack[i];
  // tx_start is a one-cycle strobe, tx_data holds until the one-cycle tx_done from the serializer.
  logic [NUM_REQ-1:0]             req;
  logic [UART_BYTE_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]             req_last;
  logic [NUM_REQ-1:0]             ack;
  logic                           tx_start;
  logic [UART_BYTE_W-1:0]         tx_data;
  logic                           tx_done;
  logic [NUM_REQ-1:0]             grant;
  logic                           busy;
  logic                           err_timeout;

  modport slave (
    input  req, req_data, req_last, tx_done,
    output ack, tx_start, tx_data, grant, busy, err_timeout
  );

  modport master (
    output req, req_data, req_last, tx_done,
    input  ack, tx_start, tx_data, grant, busy, err_timeout
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first request strictly after ptr_i, wrapping, as a one-hot grant.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic          any_o
);

  // Scan from the farthest candidate to the nearest so the nearest set bit overwrites the rest.
  always_comb begin
    int unsigned idx;
    gnt_o = '0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(ptr_i) + k) % N;
      if (req_i[PW'(idx)]) begin
        gnt_o            = '0;
        gnt_o[PW'(idx)]  = 1'b1;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX serializer among NUM_REQ byte producers, with a done watchdog.
// Optional packet lock (stay on one requester until req_last) is enabled with `define ARB_LOCK_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 16384,
  parameter int CLK_PER_BITS   = DEF_CLK_PER_BITS
) (
  input  logic               clk,
  input  logic               rst,
  uart_tx_arbiter_if.slave   bus,
  output arb_state_e         state_o
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES);
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT_CYCLES - 1);

  if (TIMEOUT_CYCLES <= min_timeout(CLK_PER_BITS)) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must exceed 10*CLK_PER_BITS");
  end

  arb_state_e             state_q, state_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [PW-1:0]          sel_q, sel_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [UART_BYTE_W-1:0] data_q, data_d;
  logic [WW-1:0]          wd_q, wd_d;

  logic [NUM_REQ-1:0]     req_eff;
  logic [NUM_REQ-1:0]     pick_gnt;
  logic                   pick_any;
  logic [PW-1:0]          pick_idx;
  logic [UART_BYTE_W-1:0] pick_data;

`ifdef ARB_LOCK_EN
  logic               lock_q, lock_d;
  logic               last_q, last_d;
  logic [NUM_REQ-1:0] sel_oh;

  // While locked only the owner may win, so the pointer is irrelevant to the pick.
  always_comb begin
    sel_oh        = '0;
    sel_oh[sel_q] = 1'b1;
    req_eff       = lock_q ? (bus.req & sel_oh) : bus.req;
  end
`else
  logic unused_req_last;
  assign unused_req_last = ^bus.req_last;
  assign req_eff         = bus.req;
`endif

  rr_pick #(.N(NUM_REQ), .PW(PW)) u_rr_pick (
    .req_i (req_eff),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .any_o (pick_any)
  );

  always_comb begin
    pick_idx  = '0;
    pick_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt[i]) begin
        pick_idx  = PW'(i);
        pick_data = bus.req_data[i*UART_BYTE_W +: UART_BYTE_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    data_d  = data_q;
    wd_d    = '0;
`ifdef ARB_LOCK_EN
    lock_d  = lock_q;
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          sel_d   = pick_idx;
          grant_d = pick_gnt;
          data_d  = pick_data;
`ifdef ARB_LOCK_EN
          last_d  = |(bus.req_last & pick_gnt);
`endif
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        // tx_done takes priority over a watchdog expiring in the same cycle.
        if (bus.tx_done) begin
          grant_d = '0;
          state_d = IDLE;
`ifdef ARB_LOCK_EN
          if (last_q) begin
            ptr_d  = sel_q;
            lock_d = 1'b0;
          end else begin
            lock_d = 1'b1;
          end
`else
          ptr_d   = sel_q;
`endif
        end else if (wd_q == WD_MAX) begin
          grant_d = '0;
          ptr_d   = sel_q;
          state_d = IDLE;
`ifdef ARB_LOCK_EN
          lock_d  = 1'b0;
`endif
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= PW'(NUM_REQ - 1);
      sel_q   <= '0;
      grant_q <= '0;
      data_q  <= '0;
      wd_q    <= '0;
`ifdef ARB_LOCK_EN
      lock_q  <= 1'b0;
      last_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      wd_q    <= wd_d;
`ifdef ARB_LOCK_EN
      lock_q  <= lock_d;
      last_q  <= last_d;
`endif
    end
  end

  assign bus.ack         = (state_q == ISSUE) ? grant_q : '0;
  assign bus.tx_start    = (state_q == ISSUE);
  assign bus.tx_data     = data_q;
  assign bus.grant       = grant_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.err_timeout = (state_q == WAIT_DONE) && !bus.tx_done && (wd_q == WD_MAX);
  assign state_o         = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed requester loads, a TX serializer model and a start monitor.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int N       = 4;
  localparam int TIMEOUT = 16384;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();
  arb_state_e state;

  uart_tx_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (TIMEOUT),
    .CLK_PER_BITS   (1086)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [11:0] exp_q[$];
  logic [8:0]  src_q[N][$];
  int          rise_cyc[N];

  int tx_delay  = 5;
  bit tx_hang   = 1'b0;
  bit chk_gap   = 1'b0;
  bit chk_lat   = 1'b0;
  bit err_allow = 1'b0;
  int lat_idx   = 0;
  int err_cnt   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic load(input int idx, input logic last, input logic [7:0] d);
    src_q[idx].push_back({last, d});
  endtask

  task automatic push_exp(input int idx, input logic [7:0] d);
    logic [3:0] g;
    g = 4'b0001 << idx;
    exp_q.push_back({g, d});
  endtask

  function automatic bit src_empty();
    for (int i = 0; i < N; i++) if (src_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.busy && src_empty()) ok = 1'b1;
    end
    check("wait_idle", 32'(ok), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Requesters: hold req with the head byte until acked, then present the next one.
  initial begin
    logic [N-1:0] ack_s;
    bus.req      = '0;
    bus.req_data = '0;
    bus.req_last = '0;
    forever begin
      @(negedge clk);
      ack_s = bus.ack;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (ack_s[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) begin
          if (!bus.req[i]) rise_cyc[i] = cyc;
          bus.req[i]           = 1'b1;
          bus.req_data[i*8 +: 8] = src_q[i][0][7:0];
          bus.req_last[i]      = src_q[i][0][8];
        end else begin
          bus.req[i] = 1'b0;
        end
      end
    end
  end

  // Serializer model: tx_done tx_delay cycles after tx_start, unless hung.
  initial begin
    bus.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_start && !tx_hang) begin
        repeat (tx_delay) @(posedge clk);
        #1 bus.tx_done = 1'b1;
        @(posedge clk);
        #1 bus.tx_done = 1'b0;
      end
    end
  end

  // Monitor: pops the expected transfer on every tx_start and checks timing relations.
  initial begin
    int          start_cyc;
    int          done_cyc;
    bit          done_since;
    bit          done_pend;
    bit          err_pend;
    logic [11:0] e;
    start_cyc  = 0;
    done_cyc   = 0;
    done_since = 1'b0;
    done_pend  = 1'b0;
    err_pend   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        done_since = 1'b0;
        done_pend  = 1'b0;
        err_pend   = 1'b0;
      end else begin
        if (done_pend) begin
          check("busy_after_done", 32'(bus.busy), 32'd0);
          check("grant_after_done", 32'(bus.grant), 32'd0);
          done_pend = 1'b0;
        end
        if (err_pend) begin
          check("grant_after_timeout", 32'(bus.grant), 32'd0);
          err_pend = 1'b0;
        end
        if (bus.tx_start) begin
          check("expected_entry", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("tx_data", 32'(bus.tx_data), 32'(e[7:0]));
            check("grant", 32'(bus.grant), 32'(e[11:8]));
            check("ack", 32'(bus.ack), 32'(e[11:8]));
            if (chk_lat) check("req_to_start", 32'(cyc - rise_cyc[lat_idx]), 32'd1);
            if (chk_gap && done_since) check("done_to_start", 32'(cyc - done_cyc), 32'd2);
          end
          start_cyc  = cyc;
          done_since = 1'b0;
        end
        if (bus.tx_done && bus.busy) begin
          done_cyc   = cyc;
          done_since = 1'b1;
          done_pend  = 1'b1;
        end
        if (bus.err_timeout) begin
          err_cnt++;
          check("err_allowed", 32'(err_allow), 32'd1);
          check("timeout_latency", 32'(cyc - start_cyc), 32'(TIMEOUT));
          err_pend = 1'b1;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation exceeded its time limit at cycle %0d", cyc);
    $fatal(1, "global timeout");
  end

  initial begin
    bit ok;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_tx_start", 32'(bus.tx_start), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_err", 32'(bus.err_timeout), 32'd0);
    check("rst_state", 32'(state), 32'(IDLE));
    rst = 1'b0;

    // Single requester with a full-frame transmit time.
    tx_delay = 10860;
    lat_idx  = 2;
    chk_lat  = 1'b1;
    load(2, 1'b1, 8'hA5);
    push_exp(2, 8'hA5);
    wait_idle(12000);
    chk_lat  = 1'b0;
    tx_delay = 5;

    // All four held high: 0,1,2,3,0 with back-to-back spacing.
    do_reset();
    chk_gap = 1'b1;
    load(0, 1'b1, 8'h10); load(1, 1'b1, 8'h11); load(2, 1'b1, 8'h12);
    load(3, 1'b1, 8'h13); load(0, 1'b1, 8'h10);
    push_exp(0, 8'h10); push_exp(1, 8'h11); push_exp(2, 8'h12);
    push_exp(3, 8'h13); push_exp(0, 8'h10);
    wait_idle(500);
    chk_gap = 1'b0;

    // Pointer wrap: after requester 1, req=1010 gives 3 then 1.
    do_reset();
    load(1, 1'b1, 8'h21);
    push_exp(1, 8'h21);
    wait_idle(200);
    load(1, 1'b1, 8'h22); load(3, 1'b1, 8'h33);
    push_exp(3, 8'h33); push_exp(1, 8'h22);
    wait_idle(200);

    // Hung transmitter: watchdog abort, then the other requester wins.
    do_reset();
    tx_hang   = 1'b1;
    err_allow = 1'b1;
    load(0, 1'b1, 8'h40); load(0, 1'b1, 8'h42); load(1, 1'b1, 8'h41);
    push_exp(0, 8'h40); push_exp(1, 8'h41); push_exp(0, 8'h42);
    ok = 1'b0;
    for (int k = 0; k < 17000 && !ok; k++) begin
      @(negedge clk);
      if (bus.err_timeout) ok = 1'b1;
    end
    check("timeout_seen", 32'(ok), 32'd1);
    tx_hang = 1'b0;
    wait_idle(300);
    err_allow = 1'b0;

    // Reset in WAIT_DONE: everything clears and requester 0 wins first.
    do_reset();
    tx_hang = 1'b1;
    load(2, 1'b1, 8'h52);
    push_exp(2, 8'h52);
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (state == WAIT_DONE) ok = 1'b1;
    end
    check("reached_wait_done", 32'(ok), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ack", 32'(bus.ack), 32'd0);
    check("midrst_tx_start", 32'(bus.tx_start), 32'd0);
    check("midrst_tx_data", 32'(bus.tx_data), 32'd0);
    check("midrst_grant", 32'(bus.grant), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_err", 32'(bus.err_timeout), 32'd0);
    check("midrst_state", 32'(state), 32'(IDLE));
    rst     = 1'b0;
    tx_hang = 1'b0;
    load(0, 1'b1, 8'h55); load(3, 1'b1, 8'h53);
    push_exp(0, 8'h55); push_exp(3, 8'h53);
    wait_idle(200);

    // Packet of three from requester 1 against a steady requester 0.
    do_reset();
    load(0, 1'b1, 8'h60);
    push_exp(0, 8'h60);
    wait_idle(200);
    load(1, 1'b0, 8'h61); load(1, 1'b0, 8'h62); load(1, 1'b1, 8'h63);
    load(0, 1'b1, 8'h64); load(0, 1'b1, 8'h65);
`ifdef ARB_LOCK_EN
    push_exp(1, 8'h61); push_exp(1, 8'h62); push_exp(1, 8'h63);
    push_exp(0, 8'h64); push_exp(0, 8'h65);
`else
    push_exp(1, 8'h61); push_exp(0, 8'h64); push_exp(1, 8'h62);
    push_exp(0, 8'h65); push_exp(1, 8'h63);
`endif
    wait_idle(400);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("err_count", 32'(err_cnt), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
